// File: rtl/mul_queue_pkg.sv
// Shared constants and types for the multiply operand queue.
// Holds the operand width, host register map, STAT/CTRL bit positions,
// the dispatch state encoding and the operand pair layout.
package mul_queue_pkg;

   localparam int OPW = 24;

   localparam logic [15:0] ADDR_A1   = 16'h0400;
   localparam logic [15:0] ADDR_A2   = 16'h0404;
   localparam logic [15:0] ADDR_STAT = 16'h0408;
   localparam logic [15:0] ADDR_CTRL = 16'h040C;

   localparam int STAT_EMPTY    = 8;
   localparam int STAT_FULL     = 9;
   localparam int STAT_A1_PEND  = 10;
   localparam int STAT_OVF      = 11;
   localparam int STAT_SEQ_ERR  = 12;
   localparam int STAT_OP_VALID = 13;

   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_FLUSH  = 1;
   localparam int CTRL_CLEAR  = 2;

   typedef enum logic {
      IDLE,
      OFFER
   } disp_state_t;

   typedef struct packed {
      logic [OPW-1:0] a1;
      logic [OPW-1:0] a2;
   } op_pair_t;

endpackage

// File: rtl/mul_op_fifo.sv
// Synchronous FIFO holding queued operand pairs.
// Read data is show-ahead (head entry always visible on rdata).
// A push into a full FIFO is ignored, even when a pop happens in the same
// cycle; flush empties the FIFO and overrides any push in that cycle.
module mul_op_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] rdata,
   output logic [AW:0]      level,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign rdata   = mem[rd_ptr];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   // Storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mul_operand_queue.sv
// Operand queue feeding the 24x24 multiply/popcount core.
// Host writes A1 then A2; each completed pair is queued and handed to the
// core over a valid/ready handshake, back-to-back when pairs are waiting.
// Optional build macro MOQ_BYPASS_EN: when the queue is empty and the
// dispatcher idle, a completing A2 write loads the core operands directly,
// saving one cycle of latency and leaving the FIFO untouched.
module mul_operand_queue
   import mul_queue_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic           clk,
   input  logic           n_reset,
   input  logic [15:0]    saddress,
   input  logic           swr,
   input  logic           srd,
   input  logic [31:0]    sdata_in,
   output logic [31:0]    sdata_out,
   output logic [OPW-1:0] op_a1,
   output logic [OPW-1:0] op_a2,
   output logic           op_valid,
   input  logic           op_ready
);

   localparam int AW = $clog2(DEPTH);

   logic           swr_q;
   logic           srd_q;
   logic           wr_pulse;
   logic           rd_pulse;
   logic           wr_a1;
   logic           wr_a2;
   logic           wr_ctrl;
   logic           flush;
   logic           pair_ok;
   logic           bypass;
   logic           push;
   logic           pop;
   logic           avail;

   logic [OPW-1:0] a1_hold;
   logic           a1_pend;
   logic           ovf;
   logic           seq_err;
   logic           enable;
   logic [15:0]    disp_cnt;
   disp_state_t    state;

   op_pair_t       new_pair;
   op_pair_t       head_pair;
   logic [AW:0]    fifo_level;
   logic           fifo_full;
   logic           fifo_empty;
   logic [31:0]    stat_word;
   logic           unused_bits;

   assign unused_bits = ^sdata_in[31:OPW];

   // Host strobe history for rising-edge detection
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         swr_q <= 1'b0;
         srd_q <= 1'b0;
      end else begin
         swr_q <= swr;
         srd_q <= srd;
      end
   end

   assign wr_pulse = swr && !swr_q;
   assign rd_pulse = srd && !srd_q;
   assign wr_a1    = wr_pulse && (saddress == ADDR_A1);
   assign wr_a2    = wr_pulse && (saddress == ADDR_A2);
   assign wr_ctrl  = wr_pulse && (saddress == ADDR_CTRL);
   assign flush    = wr_ctrl && sdata_in[CTRL_FLUSH];

   assign new_pair.a1 = a1_hold;
   assign new_pair.a2 = sdata_in[OPW-1:0];
   assign pair_ok     = wr_a2 && a1_pend && !fifo_full;

`ifdef MOQ_BYPASS_EN
   assign bypass = pair_ok && fifo_empty && (state == IDLE) && enable && !flush;
`else
   assign bypass = 1'b0;
`endif

   assign push  = pair_ok && !bypass;
   assign avail = !fifo_empty && !flush;
   assign pop   = enable && avail &&
                  ((state == IDLE) || ((state == OFFER) && op_ready));

   mul_op_fifo #(
      .WIDTH ($bits(op_pair_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .n_reset (n_reset),
      .push    (push),
      .wdata   (new_pair),
      .pop     (pop),
      .flush   (flush),
      .rdata   (head_pair),
      .level   (fifo_level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Staging register, sticky error flags and control bits from host writes
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         a1_hold <= '0;
         a1_pend <= 1'b0;
         ovf     <= 1'b0;
         seq_err <= 1'b0;
         enable  <= 1'b1;
      end else begin
         if (wr_a1) begin
            a1_hold <= sdata_in[OPW-1:0];
            a1_pend <= 1'b1;
         end
         if (wr_a2) begin
            a1_pend <= 1'b0;
            if (!a1_pend) begin
               seq_err <= 1'b1;
            end else if (fifo_full) begin
               ovf <= 1'b1;
            end
         end
         if (wr_ctrl) begin
            enable <= sdata_in[CTRL_ENABLE];
            if (sdata_in[CTRL_FLUSH]) begin
               a1_pend <= 1'b0;
            end
            if (sdata_in[CTRL_CLEAR]) begin
               ovf     <= 1'b0;
               seq_err <= 1'b0;
            end
         end
      end
   end

   // Dispatch FSM: offers one pair at a time, reloads straight from the
   // queue on a handshake so consecutive pairs go out without a bubble
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state    <= IDLE;
         op_a1    <= '0;
         op_a2    <= '0;
         op_valid <= 1'b0;
         disp_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  op_a1    <= head_pair.a1;
                  op_a2    <= head_pair.a2;
                  op_valid <= 1'b1;
                  state    <= OFFER;
               end else if (bypass) begin
                  op_a1    <= new_pair.a1;
                  op_a2    <= new_pair.a2;
                  op_valid <= 1'b1;
                  state    <= OFFER;
               end
            end
            OFFER: begin
               if (op_ready) begin
                  disp_cnt <= disp_cnt + 16'd1;
                  if (pop) begin
                     op_a1 <= head_pair.a1;
                     op_a2 <= head_pair.a2;
                  end else begin
                     op_valid <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end
            default: begin
               op_valid <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   // Status word assembled from queue state, flags and dispatch count
   always_comb begin
      stat_word                = '0;
      stat_word[7:0]           = 8'(fifo_level);
      stat_word[STAT_EMPTY]    = fifo_empty;
      stat_word[STAT_FULL]     = fifo_full;
      stat_word[STAT_A1_PEND]  = a1_pend;
      stat_word[STAT_OVF]      = ovf;
      stat_word[STAT_SEQ_ERR]  = seq_err;
      stat_word[STAT_OP_VALID] = op_valid;
      stat_word[31:16]         = disp_cnt;
   end

   // Read data captured on a read strobe and held until the next read
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         sdata_out <= '0;
      end else if (rd_pulse) begin
         case (saddress)
            ADDR_A1:   sdata_out <= 32'(a1_hold);
            ADDR_STAT: sdata_out <= stat_word;
            default:   sdata_out <= '0;
         endcase
      end
   end

endmodule
